mac8_acc_commit_buf: RTL and testbench

//  Commit-side buffer for the MAC8 accumulator. The MAC8 FU updates its

---
 rtl/mac8_acc_commit_buf.sv | 90 +++++++++
 tb/tb_mac8_acc_commit_buf.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac8_acc_commit_buf.sv
// rtl/mac8_acc_commit_buf.sv - speculative MAC8 accumulator queue with in-order commit and flush
// Holds FU results by trans_id until the commit stage retires them into the architectural accumulator.
module mac8_acc_commit_buf #(
  parameter int DEPTH         = 4,
  parameter int TRANS_ID_BITS = 3,
  parameter int XLEN          = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         wr_valid_i,
  input  logic [TRANS_ID_BITS-1:0]     wr_trans_id_i,
  input  logic [XLEN-1:0]              wr_acc_i,
  output logic                         wr_ready_o,
  input  logic                         commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0]     commit_trans_id_i,
  output logic                         commit_err_o,
  output logic [XLEN-1:0]              acc_committed_o,
  output logic [XLEN-1:0]              acc_spec_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [TRANS_ID_BITS-1:0] id_q  [DEPTH];
  logic [XLEN-1:0]          val_q [DEPTH];
  logic [PW-1:0]            rd_ptr_q, wr_ptr_q, last_ptr;
  logic [CW-1:0]            count_q;
  logic [XLEN-1:0]          acc_q;
  logic                     err_q;
  logic                     push, pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign wr_ready_o = !full_o;

  // Commit looks at the head as registered; a same-cycle push never satisfies it.
  assign pop  = commit_valid_i && !empty_o && (id_q[rd_ptr_q] == commit_trans_id_i);
  assign push = wr_valid_i && wr_ready_o && !flush_i;

  assign last_ptr   = wr_ptr_q - PW'(1);
  assign acc_spec_o = empty_o ? acc_q : val_q[last_ptr];

  assign count_o         = count_q;
  assign acc_committed_o = acc_q;
  assign commit_err_o    = err_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_ptr_q]  <= wr_trans_id_i;
      val_q[wr_ptr_q] <= wr_acc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= commit_valid_i && !pop;
      if (pop) begin
        acc_q <= val_q[rd_ptr_q];
      end
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (push && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mac8_acc_commit_buf.sv
// tb/tb_mac8_acc_commit_buf.sv - randomized and directed bench for mac8_acc_commit_buf
// A queue-based reference model tracks the buffer; outputs are compared every falling edge.
module tb_mac8_acc_commit_buf;

  localparam int DEPTH = 4;
  localparam int IDB   = 3;
  localparam int XLEN  = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            wr_valid_i = 1'b0;
  logic [IDB-1:0]  wr_trans_id_i = '0;
  logic [XLEN-1:0] wr_acc_i = '0;
  logic            wr_ready_o;
  logic            commit_valid_i = 1'b0;
  logic [IDB-1:0]  commit_trans_id_i = '0;
  logic            commit_err_o;
  logic [XLEN-1:0] acc_committed_o;
  logic [XLEN-1:0] acc_spec_o;
  logic [2:0]      count_o;
  logic            empty_o;
  logic            full_o;

  int total = 0;
  int bad   = 0;

  mac8_acc_commit_buf #(.DEPTH(DEPTH), .TRANS_ID_BITS(IDB), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .wr_valid_i(wr_valid_i), .wr_trans_id_i(wr_trans_id_i), .wr_acc_i(wr_acc_i),
    .wr_ready_o(wr_ready_o), .commit_valid_i(commit_valid_i),
    .commit_trans_id_i(commit_trans_id_i), .commit_err_o(commit_err_o),
    .acc_committed_o(acc_committed_o), .acc_spec_o(acc_spec_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IDB-1:0]  id;
    logic [XLEN-1:0] val;
  } ent_t;

  ent_t            mq[$];
  logic [XLEN-1:0] m_acc = '0;
  logic            m_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: in-order queue; commit matches the old head, flush empties after commit.
  always @(posedge clk_i or posedge rst_i) begin
    bit pop;
    bit was_full;
    if (rst_i) begin
      mq.delete();
      m_acc = '0;
      m_err = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      pop = commit_valid_i && (mq.size() > 0) && (mq[0].id == commit_trans_id_i);
      if (pop) m_acc = mq[0].val;
      m_err = commit_valid_i && !pop;
      if (flush_i) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (wr_valid_i && !was_full) mq.push_back({wr_trans_id_i, wr_acc_i});
      end
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("count", 32'(count_o), 32'(mq.size()));
      chk("empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
      chk("wr_ready", 32'(wr_ready_o), 32'(mq.size() != DEPTH));
      chk("acc_committed", acc_committed_o, m_acc);
      chk("acc_spec", acc_spec_o, (mq.size() > 0) ? mq[mq.size()-1].val : m_acc);
      chk("commit_err", 32'(commit_err_o), 32'(m_err));
    end
  end

  task automatic cyc(input bit fl, input bit wv, input int wid, input logic [XLEN-1:0] wv_acc,
                     input bit cv, input int cid);
    flush_i           = fl;
    wr_valid_i        = wv;
    wr_trans_id_i     = IDB'(wid);
    wr_acc_i          = wv_acc;
    commit_valid_i    = cv;
    commit_trans_id_i = IDB'(cid);
    @(negedge clk_i);
    flush_i        = 1'b0;
    wr_valid_i     = 1'b0;
    commit_valid_i = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] v;
    logic [XLEN-1:0] pend;
    int pend_id;

    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_ready", 32'(wr_ready_o), 1);
    chk("rst_acc", acc_committed_o, 0);
    chk("rst_spec", acc_spec_o, 0);
    chk("rst_err", 32'(commit_err_o), 0);

    // 1: two pushes, commit the older one
    cyc(0, 1, 1, 32'h10, 0, 0);
    cyc(0, 1, 2, 32'h25, 0, 0);
    chk("t1_count", 32'(count_o), 2);
    chk("t1_spec", acc_spec_o, 32'h25);
    chk("t1_acc0", acc_committed_o, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("t1_acc", acc_committed_o, 32'h10);
    chk("t1_count1", 32'(count_o), 1);
    cyc(0, 0, 0, 0, 1, 2);

    // 2: fill, dropped overflow push, drain in order
    for (int i = 0; i < 4; i++) cyc(0, 1, i, 32'hA0 + 32'(i), 0, 0);
    chk("t2_full", 32'(full_o), 1);
    chk("t2_ready", 32'(wr_ready_o), 0);
    cyc(0, 1, 4, 32'hFF, 0, 0);
    chk("t2_count", 32'(count_o), 4);
    chk("t2_spec", acc_spec_o, 32'hA3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, i);
    chk("t2_acc", acc_committed_o, 32'hA3);
    chk("t2_empty", 32'(empty_o), 1);

    // 3: flush with a same-cycle commit
    cyc(0, 1, 5, 32'h7, 0, 0);
    cyc(0, 1, 6, 32'h9, 0, 0);
    cyc(1, 0, 0, 0, 1, 5);
    chk("t3_acc", acc_committed_o, 32'h7);
    chk("t3_count", 32'(count_o), 0);
    chk("t3_spec", acc_spec_o, 32'h7);

    // 4: mismatched commit and commit on empty
    cyc(0, 1, 2, 32'h3, 0, 0);
    cyc(0, 0, 0, 0, 1, 3);
    chk("t4_err", 32'(commit_err_o), 1);
    chk("t4_count", 32'(count_o), 1);
    chk("t4_acc", acc_committed_o, 32'h7);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t4_err_gone", 32'(commit_err_o), 0);
    cyc(0, 0, 0, 0, 1, 2);
    chk("t4_acc3", acc_committed_o, 32'h3);
    cyc(0, 0, 0, 0, 1, 2);
    chk("t4_err_empty", 32'(commit_err_o), 1);

    // 5: overlapped push/commit across pointer wrap
    pend = $urandom;
    pend_id = 0;
    cyc(0, 1, pend_id, pend, 0, 0);
    for (int k = 1; k < 10; k++) begin
      v = $urandom;
      cyc(0, 1, k % 8, v, 1, pend_id);
      chk("t5_count", 32'(count_o), 1);
      chk("t5_acc", acc_committed_o, pend);
      chk("t5_err", 32'(commit_err_o), 0);
      pend = v;
      pend_id = k % 8;
    end
    cyc(0, 0, 0, 0, 1, pend_id);
    chk("t5_last", acc_committed_o, pend);

    // Random traffic, mostly committing the expected head
    for (int n = 0; n < 400; n++) begin
      bit fl, wv, cv;
      int cid;
      fl  = ($urandom_range(0, 19) == 0);
      wv  = ($urandom_range(0, 2) != 0);
      cv  = ($urandom_range(0, 1) != 0);
      cid = $urandom_range(0, 7);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) cid = int'(mq[0].id);
      cyc(fl, wv, $urandom_range(0, 7), $urandom, cv, cid);
    end

    // 6: async reset with three entries queued
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h11, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 2, 32'h22, 0, 0);
    cyc(0, 1, 3, 32'h33, 0, 0);
    cyc(0, 1, 4, 32'h44, 0, 0);
    chk("t6_pre", 32'(count_o), 3);
    chk("t6_pre_acc", acc_committed_o, 32'h11);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_count", 32'(count_o), 0);
    chk("t6_acc", acc_committed_o, 0);
    chk("t6_spec", acc_spec_o, 0);
    chk("t6_ready", 32'(wr_ready_o), 1);
    chk("t6_empty", 32'(empty_o), 1);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc(0, 1, 7, 32'h5A, 0, 0);
    cyc(0, 0, 0, 0, 1, 7);
    chk("t6_after", acc_committed_o, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
